// File: rtl/rr_arb_16.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb_16
//  Purpose  : 16-way round-robin arbiter with one-hot and binary grant outputs,
//             owner release via done/req drop and optional hold timeout.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb_16 #(
  parameter int N        = 16,
  parameter int LOGN     = 4,
  parameter int MAX_HOLD = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [LOGN-1:0] gnt_idx,
  output logic            gnt_valid
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [7:0]     C_MAX_HOLD = 8'(MAX_HOLD);
  localparam logic [7:0]     C_HOLD_SAT = 8'hFF;
  localparam logic [N-1:0]   C_ONE      = {{(N-1){1'b0}}, 1'b1};
  localparam logic [LOGN-1:0] C_IDX_ONE = {{(LOGN-1){1'b0}}, 1'b1};

  state_t          r_state;
  state_t          w_state_nxt;
  logic [LOGN-1:0] r_ptr;
  logic [LOGN-1:0] w_ptr_nxt;
  logic [7:0]      r_hold_cnt;
  logic [7:0]      w_hold_nxt;
  logic [N-1:0]    r_gnt;
  logic [N-1:0]    w_gnt_nxt;
  logic [LOGN-1:0] r_idx;
  logic [LOGN-1:0] w_idx_nxt;
  logic            r_valid;
  logic            w_valid_nxt;

  logic            w_found;
  logic [LOGN-1:0] w_win;
  logic [LOGN-1:0] w_cand;
  logic            w_timeout;
  logic            w_release;

  // Rotating priority search: candidates ptr, ptr+1, ... wrap naturally in LOGN bits.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = r_ptr + LOGN'(k);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_timeout = (MAX_HOLD != 0) && (r_hold_cnt == C_MAX_HOLD);
  assign w_release = done | ~req[r_idx] | w_timeout;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold_cnt;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = C_ONE << w_win;
          w_idx_nxt   = w_win;
          w_valid_nxt = 1'b1;
          w_hold_nxt  = 8'd1;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          // gnt_idx is deliberately left holding the last owner.
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_valid_nxt = 1'b0;
          w_ptr_nxt   = r_idx + C_IDX_ONE;
          w_hold_nxt  = 8'd0;
        end else if (r_hold_cnt != C_HOLD_SAT) begin
          w_hold_nxt  = r_hold_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= 8'd0;
      r_gnt      <= '0;
      r_idx      <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gnt      <= w_gnt_nxt;
      r_idx      <= w_idx_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = r_valid;

endmodule
`default_nettype wire
